// File: rtl/instr_controller.sv
// instr_controller: multi-cycle control FSM for a small register-file datapath.
// Latches a 16-bit instruction on a start pulse, decodes it, and sequences
// the datapath through reads, the ALU operation and the writeback.
module instr_controller (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        s,
  input  logic [15:0] in,
  output logic        w,
  output logic        illegal,
  output logic [2:0]  readnum,
  output logic [2:0]  writenum,
  output logic [3:0]  vsel,
  output logic        loada,
  output logic        loadb,
  output logic        loadc,
  output logic        loads,
  output logic        asel,
  output logic        bsel,
  output logic        write,
  output logic [1:0]  shift,
  output logic [1:0]  ALUop,
  output logic [15:0] sximm8,
  output logic [15:0] sximm5
);

  typedef enum logic [2:0] {
    S_WAIT,
    S_DECODE,
    S_WRITE_IMM,
    S_GET_A,
    S_GET_B,
    S_ALU,
    S_WRITE_REG
  } state_t;

  state_t      state_q, state_d;
  logic [15:0] ir_q, ir_d;
  logic        illegal_q, illegal_d;

  logic [2:0] opcode, rn, rd, rm;
  logic [1:0] op, sh;
  logic       is_mov_imm, is_mov_reg, is_alu, is_mvn, is_cmp;

  assign opcode = ir_q[15:13];
  assign op     = ir_q[12:11];
  assign rn     = ir_q[10:8];
  assign rd     = ir_q[7:5];
  assign sh     = ir_q[4:3];
  assign rm     = ir_q[2:0];

  assign is_mov_imm = (opcode == 3'b110) && (op == 2'b10);
  assign is_mov_reg = (opcode == 3'b110) && (op == 2'b00);
  assign is_alu     = (opcode == 3'b101);
  assign is_mvn     = is_alu && (op == 2'b11);
  assign is_cmp     = is_alu && (op == 2'b01);

  assign sximm8  = {{8{ir_q[7]}}, ir_q[7:0]};
  assign sximm5  = {{11{ir_q[4]}}, ir_q[4:0]};
  assign illegal = illegal_q;

  // State, instruction register and illegal flag; reset aborts any instruction.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= S_WAIT;
      ir_q      <= 16'h0000;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      ir_q      <= ir_d;
      illegal_q <= illegal_d;
    end
  end

  // Next-state logic: accept in WAIT, dispatch on the decoded IR, then sequence.
  always_comb begin
    state_d   = state_q;
    ir_d      = ir_q;
    illegal_d = illegal_q;
    case (state_q)
      S_WAIT: begin
        if (s) begin
          state_d   = S_DECODE;
          ir_d      = in;
          illegal_d = 1'b0;
        end
      end
      S_DECODE: begin
        if (is_mov_imm) begin
          state_d = S_WRITE_IMM;
        end else if (is_mov_reg || is_mvn) begin
          state_d = S_GET_B;
        end else if (is_alu) begin
          state_d = S_GET_A;
        end else begin
          state_d   = S_WAIT;
          illegal_d = 1'b1;
        end
      end
      S_WRITE_IMM: state_d = S_WAIT;
      S_GET_A:     state_d = S_GET_B;
      S_GET_B:     state_d = S_ALU;
      S_ALU:       state_d = is_cmp ? S_WAIT : S_WRITE_REG;
      S_WRITE_REG: state_d = S_WAIT;
      default:     state_d = S_WAIT;
    endcase
  end

  // Moore outputs: everything idle by default, each state raises only its own controls.
  always_comb begin
    w        = 1'b0;
    readnum  = 3'd0;
    writenum = 3'd0;
    vsel     = 4'b0001;
    loada    = 1'b0;
    loadb    = 1'b0;
    loadc    = 1'b0;
    loads    = 1'b0;
    asel     = 1'b0;
    bsel     = 1'b0;
    write    = 1'b0;
    shift    = 2'b00;
    ALUop    = 2'b00;
    case (state_q)
      S_WAIT: w = 1'b1;
      S_WRITE_IMM: begin
        vsel     = 4'b0100;
        writenum = rn;
        write    = 1'b1;
      end
      S_GET_A: begin
        readnum = rn;
        loada   = 1'b1;
      end
      S_GET_B: begin
        readnum = rm;
        loadb   = 1'b1;
      end
      S_ALU: begin
        shift = sh;
        if (is_mov_reg) begin
          asel  = 1'b1;
          ALUop = 2'b00;
        end else begin
          asel  = 1'b0;
          ALUop = op;
        end
        if (is_cmp) begin
          loads = 1'b1;
        end else begin
          loadc = 1'b1;
        end
      end
      S_WRITE_REG: begin
        vsel     = 4'b0001;
        writenum = rd;
        write    = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_instr_controller.sv
// tb_instr_controller: scoreboard bench for instr_controller.
// A reference model expands each instruction into its expected per-cycle
// control vectors; those are queued when the start pulse is driven and
// compared one per clock as the controller steps through the instruction.
module tb_instr_controller;

  logic        clk;
  logic        reset_n;
  logic        s;
  logic [15:0] in;
  logic        w, illegal;
  logic [2:0]  readnum, writenum;
  logic [3:0]  vsel;
  logic        loada, loadb, loadc, loads, asel, bsel, write;
  logic [1:0]  shift, ALUop;
  logic [15:0] sximm8, sximm5;

  int totalCount = 0;
  int badCount   = 0;

  logic [22:0] expQ[$];
  logic [22:0] idleVec;

  instr_controller dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .s        (s),
    .in       (in),
    .w        (w),
    .illegal  (illegal),
    .readnum  (readnum),
    .writenum (writenum),
    .vsel     (vsel),
    .loada    (loada),
    .loadb    (loadb),
    .loadc    (loadc),
    .loads    (loads),
    .asel     (asel),
    .bsel     (bsel),
    .write    (write),
    .shift    (shift),
    .ALUop    (ALUop),
    .sximm8   (sximm8),
    .sximm5   (sximm5)
  );

  // Free-running clock, rising edges at 5, 15, 25, ...
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Packs one cycle's worth of control outputs into a comparable vector.
  function automatic logic [22:0] mk(input logic ew, input logic eill,
                                     input logic [2:0] ern, input logic [2:0] ewn,
                                     input logic [3:0] evs,
                                     input logic ela, input logic elb, input logic elc,
                                     input logic els, input logic eas, input logic ebs,
                                     input logic ewr, input logic [1:0] esh,
                                     input logic [1:0] ealu);
    return {ew, eill, ern, ewn, evs, ela, elb, elc, els, eas, ebs, ewr, esh, ealu};
  endfunction

  function automatic logic [22:0] obsVec();
    return {w, illegal, readnum, writenum, vsel, loada, loadb, loadc, loads,
            asel, bsel, write, shift, ALUop};
  endfunction

  // Counts every comparison and reports any mismatch.
  task automatic checkOutput(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    totalCount++;
    if (actual !== expected) begin
      badCount++;
      $display("[TB] FAIL %s: got %h expected %h", tag, actual, expected);
    end
  endtask

  // Drives one instruction at a negedge, queues the model's expected vectors,
  // then checks one vector per clock. abortAfter>0 stops early (for reset tests).
  task automatic applyStimulus(input string name, input logic [15:0] instr,
                               input int expLat, input bit holdS,
                               input int abortAfter);
    logic [2:0]  opc, rn, rd, rm;
    logic [1:0]  op, sh;
    logic        movImm, movReg, alu3, mvn, cmp, bad;
    logic [22:0] got, exp;
    int          edges, latSeen, writes, expWrites;

    opc = instr[15:13]; op = instr[12:11]; rn = instr[10:8];
    rd  = instr[7:5];   sh = instr[4:3];   rm = instr[2:0];
    movImm = (opc == 3'b110) && (op == 2'b10);
    movReg = (opc == 3'b110) && (op == 2'b00);
    alu3   = (opc == 3'b101);
    mvn    = alu3 && (op == 2'b11);
    cmp    = alu3 && (op == 2'b01);
    bad    = !(movImm || movReg || alu3);

    expQ.delete();
    expQ.push_back(mk(0,0,0,0,4'b0001,0,0,0,0,0,0,0,2'b00,2'b00));
    if (movImm) begin
      expQ.push_back(mk(0,0,0,rn,4'b0100,0,0,0,0,0,0,1,2'b00,2'b00));
    end else if (movReg || mvn) begin
      expQ.push_back(mk(0,0,rm,0,4'b0001,0,1,0,0,0,0,0,2'b00,2'b00));
      expQ.push_back(mk(0,0,0,0,4'b0001,0,0,1,0,movReg,0,0,sh,movReg ? 2'b00 : op));
      expQ.push_back(mk(0,0,0,rd,4'b0001,0,0,0,0,0,0,1,2'b00,2'b00));
    end else if (alu3) begin
      expQ.push_back(mk(0,0,rn,0,4'b0001,1,0,0,0,0,0,0,2'b00,2'b00));
      expQ.push_back(mk(0,0,rm,0,4'b0001,0,1,0,0,0,0,0,2'b00,2'b00));
      expQ.push_back(mk(0,0,0,0,4'b0001,0,0,!cmp,cmp,0,0,0,sh,op));
      if (!cmp)
        expQ.push_back(mk(0,0,0,rd,4'b0001,0,0,0,0,0,0,1,2'b00,2'b00));
    end
    expQ.push_back(mk(1,bad,0,0,4'b0001,0,0,0,0,0,0,0,2'b00,2'b00));
    expWrites = (cmp || bad) ? 0 : 1;

    in = instr;
    s  = 1'b1;
    edges = 0; latSeen = -1; writes = 0;
    while (expQ.size() > 0) begin
      @(posedge clk);
      edges++;
      @(negedge clk);
      if (!holdS || expQ.size() <= 2) s = 1'b0;
      exp = expQ.pop_front();
      got = obsVec();
      checkOutput($sformatf("%s_e%0d", name, edges), {9'd0, got}, {9'd0, exp});
      if (write) writes++;
      if (edges == 1) begin
        checkOutput($sformatf("%s_sx8", name), {16'd0, sximm8},
                    {16'd0, {{8{instr[7]}}, instr[7:0]}});
        checkOutput($sformatf("%s_sx5", name), {16'd0, sximm5},
                    {16'd0, {{11{instr[4]}}, instr[4:0]}});
      end
      if (w && latSeen < 0) latSeen = edges;
      if (abortAfter > 0 && edges >= abortAfter) begin
        expQ.delete();
        s = 1'b0;
        return;
      end
    end
    checkOutput($sformatf("%s_lat", name), latSeen, expLat);
    checkOutput($sformatf("%s_wrcnt", name), writes, expWrites);
  endtask

  // Main sequence: reset, instruction mix, illegal handling, reset abort.
  initial begin
    idleVec = mk(1,0,0,0,4'b0001,0,0,0,0,0,0,0,2'b00,2'b00);
    reset_n = 1'b0;
    s       = 1'b0;
    in      = 16'hFFFF;
    #1;
    checkOutput("reset_vec", {9'd0, obsVec()}, {9'd0, idleVec});
    checkOutput("reset_sx8", {16'd0, sximm8}, 32'h0);

    // A clock edge under reset with s high must not start anything.
    s = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("reset_hold", {9'd0, obsVec()}, {9'd0, idleVec});
    s = 1'b0;

    @(negedge clk);
    reset_n = 1'b1;
    applyStimulus("movimm", 16'hD007, 3, 0, 0);
    applyStimulus("add",    16'hA041, 6, 0, 0);
    applyStimulus("cmp",    16'hA801, 5, 0, 0);
    applyStimulus("mvn",    16'hB869, 5, 0, 0);
    applyStimulus("movreg", 16'hC0B2, 5, 0, 0);
    applyStimulus("and",    16'hB2C5, 6, 1, 0);
    applyStimulus("movneg", 16'hD4FF, 3, 0, 0);
    applyStimulus("illeg",  16'h0000, 2, 0, 0);

    // The illegal flag persists in WAIT while no new s arrives.
    @(posedge clk);
    @(negedge clk);
    checkOutput("illeg_idle", {9'd0, obsVec()},
                {9'd0, mk(1,1,0,0,4'b0001,0,0,0,0,0,0,0,2'b00,2'b00)});
    applyStimulus("illeg2", 16'hE123, 2, 0, 0);
    applyStimulus("clrill", 16'hD102, 3, 0, 0);

    // Abort an ADD while in GET_B; reset must take effect without a clock.
    applyStimulus("abort", 16'hA041, 6, 0, 3);
    reset_n = 1'b0;
    #1;
    checkOutput("abort_vec", {9'd0, obsVec()}, {9'd0, idleVec});
    checkOutput("abort_sx8", {16'd0, sximm8}, 32'h0);
    @(posedge clk);
    #1;
    checkOutput("abort_quiet", {29'd0, write, loadc, loads}, 32'h0);
    @(negedge clk);
    reset_n = 1'b1;
    applyStimulus("after", 16'hD102, 3, 0, 0);

    $display("test done: total=%0d bad=%0d", totalCount, badCount);
    $finish;
  end

  // Global watchdog so the bench always ends even if the sequence stalls.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    badCount++;
    $display("test done: total=%0d bad=%0d", totalCount, badCount);
    $finish;
  end

endmodule
